// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//
// Direct-mapped branch target buffer with a saturating direction counter in
// every entry. The IF stage looks up the fetch PC combinationally and gets a
// predicted next PC in the same cycle. Branches resolved in MEM write the
// table at the next rising edge. Two saturating counters keep statistics for
// lab measurements.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   flush_all       synchronous invalidate of every entry (beats an update)
//   lk_pc           fetch PC to look up
//   lk_hit          a valid entry's tag matches lk_pc
//   lk_taken        lk_hit and the entry's counter predicts taken
//   lk_next_pc      stored target when lk_taken, otherwise lk_pc + 4
//   upd_valid       a resolved branch is presented this cycle
//   upd_pc          PC of the resolved branch
//   upd_taken       actual direction
//   upd_target      actual taken target
//   upd_mispredict  the pipeline mispredicted this branch
//   stat_updates    saturating count of accepted updates
//   stat_mispred    saturating count of mispredicted updates
//
// Addressing: idx = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0]
// and the bits above the tag take no part. IDX_W+TAG_W+2 must not exceed
// ADDR_W.
module branch_target_predictor #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 8,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_all,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_updates,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int ENTRIES = 2 ** IDX_W;

    // Counter encodings: the MSB is the taken prediction, so the two values
    // straddling the midpoint are the "weak" states.
    localparam logic [CTR_W-1:0] CTR_MAX     = CTR_W'((2 ** CTR_W) - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((2 ** (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(2 ** (CTR_W - 1));

    // Flattened view of the per-entry registers for the shared read ports.
    logic              valid_arr  [ENTRIES];
    logic [TAG_W-1:0]  tag_arr    [ENTRIES];
    logic [ADDR_W-1:0] target_arr [ENTRIES];
    logic [CTR_W-1:0]  ctr_arr    [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup: zero latency, reads the state as it stands before this
    // cycle's update (no bypass from the update port).
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;

    assign lk_idx     = lk_pc[IDX_W+1:2];
    assign lk_tag     = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign lk_hit     = valid_arr[lk_idx] && (tag_arr[lk_idx] == lk_tag);
    assign lk_taken   = lk_hit && ctr_arr[lk_idx][CTR_W-1];
    assign lk_next_pc = lk_taken ? target_arr[lk_idx] : (lk_pc + ADDR_W'(4));

    // ------------------------------------------------------------------
    // Update port decode, shared by all entries.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_hit = valid_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);

    // Only slices of the PCs are used as index and tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc, upd_pc};

    // ------------------------------------------------------------------
    // Table entries. Each entry owns its registers so reset and flush can
    // act on all of them in one edge.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic              valid_reg;
            logic [TAG_W-1:0]  tag_reg;
            logic [ADDR_W-1:0] target_reg;
            logic [CTR_W-1:0]  ctr_reg;
            logic [CTR_W-1:0]  ctr_next;
            logic              sel;

            assign sel = upd_valid && (upd_idx == IDX_W'(gi));

            // Saturating step of the direction counter on a hit.
            always_comb begin
                ctr_next = ctr_reg;
                if (upd_taken) begin
                    if (ctr_reg != CTR_MAX) begin
                        ctr_next = ctr_reg + CTR_W'(1);
                    end
                end else begin
                    if (ctr_reg != '0) begin
                        ctr_next = ctr_reg - CTR_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_WEAK_NT;
                end else if (flush_all) begin
                    // Flush drops any concurrent update; counters and
                    // targets stay but are unreachable until reallocated.
                    valid_reg <= 1'b0;
                end else if (sel) begin
                    if (upd_hit) begin
                        ctr_reg <= ctr_next;
                        if (upd_taken) begin
                            target_reg <= upd_target;
                        end
                    end else if (upd_taken) begin
                        // Allocate on a taken miss, evicting whatever was
                        // in the slot.
                        valid_reg  <= 1'b1;
                        tag_reg    <= upd_tag;
                        target_reg <= upd_target;
                        ctr_reg    <= CTR_WEAK_T;
                    end
                end
            end

            assign valid_arr[gi]  = valid_reg;
            assign tag_arr[gi]    = tag_reg;
            assign target_arr[gi] = target_reg;
            assign ctr_arr[gi]    = ctr_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Statistics: count every presented update (even one dropped by a
    // flush), saturating at all-ones.
    // ------------------------------------------------------------------
    logic [STAT_W-1:0] stat_updates_reg;
    logic [STAT_W-1:0] stat_mispred_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_updates_reg <= '0;
            stat_mispred_reg <= '0;
        end else begin
            if (upd_valid && (stat_updates_reg != '1)) begin
                stat_updates_reg <= stat_updates_reg + STAT_W'(1);
            end
            if (upd_valid && upd_mispredict && (stat_mispred_reg != '1)) begin
                stat_mispred_reg <= stat_mispred_reg + STAT_W'(1);
            end
        end
    end

    assign stat_updates = stat_updates_reg;
    assign stat_mispred = stat_mispred_reg;

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- IF stage looks up the fetch PC in the same cycle and gets a predicted next PC.
- MEM stage branch resolution updates the table on the following clock edge.
- Replaces the fixed "resolve-in-MEM, flush on taken" PC selection. The pipeline only flushes on mispredict. Saturating statistics counters are provided for lab measurement.

Parameters:
- ADDR_W, 32, PC / target width.
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W.
- TAG_W, 8, tag bits; IDX_W+TAG_W+2 must be <= ADDR_W.
- CTR_W, 2, direction counter width, >= 1.
- STAT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_all  in  1  synchronous invalidate of every entry.
- lk_pc  in  ADDR_W  IF fetch PC.
- lk_hit  out  1  valid entry with matching tag.
- lk_taken  out  1  predict taken (lk_hit AND counter MSB).
- lk_next_pc  out  ADDR_W  lk_taken ? stored target : lk_pc+4.
- upd_valid  in  1  resolved branch this cycle.
- upd_pc  in  ADDR_W  PC of resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_mispredict  in  1  prediction was wrong (pipeline-computed).
- stat_updates  out  STAT_W  number of accepted updates.
- stat_mispred  out  STAT_W  number of mispredicts.

Behaviour:
- Addressing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry state: valid, tag, target[ADDR_W], ctr[CTR_W].
- Reset (async, rst=1):
  - all valid=0; ctr = 2**(CTR_W-1)-1 (weakly not-taken); tag/target = 0.
  - stat counters = 0.
  - Outputs are combinational and follow from this state: lk_hit=0, lk_taken=0, lk_next_pc=lk_pc+4.
- Lookup: purely combinational, zero latency.
  - lk_next_pc is computed mod 2**ADDR_W (lk_pc+4 wraps).
- Update, registered at the rising edge when upd_valid=1:
  - Hit (valid and tag match):
    - ctr saturating +1 if upd_taken, saturating -1 otherwise.
    - If upd_taken, target <= upd_target.
  - Miss and upd_taken: allocate and overwrite the slot. valid=1, tag=new, target=upd_target, ctr=2**(CTR_W-1) (weakly taken).
  - Miss and not taken: table unchanged.
  - Saturation: ctr never wraps; it stays at 0 or at 2**CTR_W-1.
- Statistics:
  - stat_updates +1 per upd_valid cycle.
  - stat_mispred +1 per cycle with upd_valid & upd_mispredict.
  - Both saturate at all-ones; no wrap.
- Simultaneous lookup and update to the same idx: lookup returns pre-update contents (no bypass). The new state is visible the next cycle.
- flush_all:
  - At the edge, clears all valid bits; ctr/target are retained but unreachable.
  - If flush_all and upd_valid occur together, flush wins: the table is cleared and the update is dropped.
  - Statistics still count that update.
- rst asserted mid-operation: immediate asynchronous clear. Any concurrent update is lost.
- CTR_W=1: ctr is a single bit, set on taken and cleared on not-taken. Allocation sets ctr=1.

Test Plan:
- Reset then lookup 0x00400000 -> lk_hit=0, lk_taken=0, lk_next_pc=0x00400004; stats=0.
- Update pc=0x00400010, taken=1, target=0x00400100 -> next-cycle lookup 0x00400010 gives hit=1, taken=1, next_pc=0x00400100. Lookup 0x00400410 (same idx, different tag) gives hit=0, next_pc=0x00400414.
- Counter saturation (CTR_W=2):
  - After allocation, three taken updates -> ctr stays 3.
  - Then one not-taken -> ctr=2, still taken.
  - A second not-taken -> ctr=1, lk_taken=0, lk_next_pc=pc+4.
- Same-cycle lookup and update of the same idx on an empty table -> lookup that cycle shows hit=0; the following cycle shows hit=1.
- flush_all asserted together with a taken update to a new PC -> all lookups miss afterwards; stat_updates incremented by 1.
- STAT_W=4 bench: 20 updates, all with upd_mispredict=1 -> stat_updates=stat_mispred=15 (saturated). Assert rst between edges -> both 0 immediately and table empty.
